// File: rtl/aes128_encrypt_core.sv
// ============================================================================
// aes128_encrypt_core
// ----------------------------------------------------------------------------
// Iterative AES-128 block encryptor (FIPS-197). It computes one full round per
// clock. Round keys are expanded on the fly from the previous round key, so no
// key schedule is stored.
//
// Ports
//   clk         in   1    system clock, all state on the rising edge
//   rst_n       in   1    asynchronous, active-high reset (historic name)
//   E_int       in   1    encrypt start request, sampled only in IDLE
//   plaintext   in   128  input block, byte0 = [127:120], column-major state
//   key         in   128  cipher key, same byte order
//   ciphertext  out  128  registered result, held until the next completion
//   E_done      out  1    one-cycle pulse, ciphertext valid
//   busy        out  1    (only with ENC_BUSY_PORT_EN) high in RUN and DONE
//
// Build option
//   ENC_BUSY_PORT_EN : when defined, adds the busy output.
//
// Timing
//   Start sampled at edge N -> E_done/ciphertext valid after edge N+10.
//   DONE lasts one cycle, so E_int held high relaunches every 12 clocks.
// ============================================================================
module aes128_encrypt_core (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         E_int,
    input  logic [127:0] plaintext,
    input  logic [127:0] key,
    output logic [127:0] ciphertext,
    output logic         E_done
`ifdef ENC_BUSY_PORT_EN
    ,
    output logic         busy
`endif
);

    localparam logic [3:0] NR = 4'd10;

    // Forward S-box, byte x at bits [8x +: 8] of an ascending vector.
    localparam logic [0:2047] SBOX_TABLE = {
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };

    function automatic logic [7:0] sbox(input logic [7:0] b);
        return SBOX_TABLE[{b, 3'b000} +: 8];
    endfunction

    // Multiply by x in GF(2^8) modulo 0x11b.
    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    // Round constant for the key word that feeds round rnd (1..10).
    function automatic logic [7:0] rcon(input logic [3:0] rnd);
        logic [7:0] rc;
        case (rnd)
            4'd1:    rc = 8'h01;
            4'd2:    rc = 8'h02;
            4'd3:    rc = 8'h04;
            4'd4:    rc = 8'h08;
            4'd5:    rc = 8'h10;
            4'd6:    rc = 8'h20;
            4'd7:    rc = 8'h40;
            4'd8:    rc = 8'h80;
            4'd9:    rc = 8'h1b;
            4'd10:   rc = 8'h36;
            default: rc = 8'h00;
        endcase
        return rc;
    endfunction

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t         state_reg, state_next;
    logic [127:0]   blk_reg,   blk_next;
    logic [127:0]   rkey_reg,  rkey_next;
    logic [127:0]   ct_reg,    ct_next;
    logic [3:0]     rnd_reg,   rnd_next;
    logic           done_reg,  done_next;

    // ------------------------------------------------------------------
    // Round datapath (combinational from blk_reg / rkey_reg)
    // ------------------------------------------------------------------
    logic [127:0]   sub_bytes;
    logic [127:0]   shift_rows;
    logic [127:0]   mix_cols;
    logic [127:0]   next_rkey;
    logic [127:0]   round_out;
    logic [31:0]    key_sub_rot;
    logic [31:0]    key_t;

    // SubBytes: one S-box per state byte.
    generate
        for (genvar gi = 0; gi < 16; gi++) begin : g_sub
            assign sub_bytes[127-8*gi -: 8] = sbox(blk_reg[127-8*gi -: 8]);
        end
    endgenerate

    // ShiftRows: state byte (row r, col c) lives at index 4c+r; row r rotates
    // left by r, so it takes the byte from column (c+r) mod 4.
    generate
        for (genvar gi = 0; gi < 16; gi++) begin : g_shift
            localparam int ROW = gi % 4;
            localparam int COL = gi / 4;
            localparam int SRC = 4 * ((COL + ROW) % 4) + ROW;
            assign shift_rows[127-8*gi -: 8] = sub_bytes[127-8*SRC -: 8];
        end
    endgenerate

    // MixColumns: each column multiplied by the circulant {02,03,01,01}.
    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_mix
            logic [7:0] a0, a1, a2, a3;
            assign a0 = shift_rows[127-32*gi      -: 8];
            assign a1 = shift_rows[127-32*gi-8    -: 8];
            assign a2 = shift_rows[127-32*gi-16   -: 8];
            assign a3 = shift_rows[127-32*gi-24   -: 8];
            assign mix_cols[127-32*gi    -: 8] = xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3;
            assign mix_cols[127-32*gi-8  -: 8] = a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3;
            assign mix_cols[127-32*gi-16 -: 8] = a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3;
            assign mix_cols[127-32*gi-24 -: 8] = xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3);
        end
    endgenerate

    // Key expansion: SubWord(RotWord(w3)); RotWord moves the top byte down,
    // so result byte gi comes from w3 byte (gi+1) mod 4.
    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_ksub
            localparam int SRC = (gi + 1) % 4;
            assign key_sub_rot[31-8*gi -: 8] = sbox(rkey_reg[31-8*SRC -: 8]);
        end
    endgenerate

    assign key_t = key_sub_rot ^ {rcon(rnd_reg), 24'h000000};

    // Word chain: each new word is the old word xor the previous new word.
    assign next_rkey[127:96] = rkey_reg[127:96] ^ key_t;
    assign next_rkey[95:64]  = rkey_reg[95:64]  ^ next_rkey[127:96];
    assign next_rkey[63:32]  = rkey_reg[63:32]  ^ next_rkey[95:64];
    assign next_rkey[31:0]   = rkey_reg[31:0]   ^ next_rkey[63:32];

    // Last round skips MixColumns.
    assign round_out = ((rnd_reg == NR) ? shift_rows : mix_cols) ^ next_rkey;

    // ------------------------------------------------------------------
    // Control FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            state_reg <= ST_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        blk_next   = blk_reg;
        rkey_next  = rkey_reg;
        rnd_next   = rnd_reg;
        ct_next    = ct_reg;
        done_next  = 1'b0;
        case (state_reg)
            ST_IDLE: begin
                if (E_int) begin
                    blk_next   = plaintext ^ key;
                    rkey_next  = key;
                    rnd_next   = 4'd1;
                    state_next = ST_RUN;
                end
            end
            ST_RUN: begin
                blk_next  = round_out;
                rkey_next = next_rkey;
                if (rnd_reg == NR) begin
                    ct_next    = round_out;
                    done_next  = 1'b1;
                    rnd_next   = 4'd0;
                    state_next = ST_DONE;
                end else begin
                    rnd_next = rnd_reg + 4'd1;
                end
            end
            ST_DONE: begin
                state_next = ST_IDLE;
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Datapath registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            blk_reg  <= '0;
            rkey_reg <= '0;
            ct_reg   <= '0;
            rnd_reg  <= '0;
            done_reg <= 1'b0;
        end else begin
            blk_reg  <= blk_next;
            rkey_reg <= rkey_next;
            ct_reg   <= ct_next;
            rnd_reg  <= rnd_next;
            done_reg <= done_next;
        end
    end

    assign ciphertext = ct_reg;
    assign E_done     = done_reg;

`ifdef ENC_BUSY_PORT_EN
    assign busy = (state_reg != ST_IDLE);
`endif

endmodule

// File: tb/tb_aes128_encrypt_core.sv
// ============================================================================
// tb_aes128_encrypt_core
// ----------------------------------------------------------------------------
// Self-checking bench for aes128_encrypt_core. The reference model derives the
// S-box from GF(2^8) inversion plus the affine map, precomputes the full key
// schedule and runs the cipher on byte arrays. Known-answer vectors are also
// checked directly. Define ENC_BUSY_PORT_EN to also check the busy output.
// ============================================================================
`timescale 1ns/1ps
module tb_aes128_encrypt_core;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         E_int;
    logic [127:0] plaintext;
    logic [127:0] key;
    logic [127:0] ciphertext;
    logic         E_done;
`ifdef ENC_BUSY_PORT_EN
    logic         busy;
`endif

    int n_cmp = 0;
    int n_bad = 0;

    logic [7:0] sbox_tab [256];

    aes128_encrypt_core dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .E_int      (E_int),
        .plaintext  (plaintext),
        .key        (key),
        .ciphertext (ciphertext),
        .E_done     (E_done)
`ifdef ENC_BUSY_PORT_EN
        ,
        .busy       (busy)
`endif
    );

    always #5 clk = ~clk;

    // ------------------------------------------------------------------
    // Reference model
    // ------------------------------------------------------------------
    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p = 8'h00;
        logic [7:0] aa = a;
        logic       hi;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ aa;
            hi = aa[7];
            aa = {aa[6:0], 1'b0} ^ (hi ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    function automatic logic [7:0] rotl8(input logic [7:0] b, input int n);
        logic [15:0] t = {b, b};
        t = t << n;
        return t[15:8];
    endfunction

    task automatic build_sbox();
        logic [7:0] inv;
        logic [7:0] x8;
        for (int x = 0; x < 256; x++) begin
            x8  = 8'(x);
            inv = 8'h00;
            for (int y = 1; y < 256; y++)
                if (x != 0 && gmul(x8, 8'(y)) == 8'h01) inv = 8'(y);
            sbox_tab[x] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3)
                          ^ rotl8(inv, 4) ^ 8'h63;
        end
    endtask

    function automatic logic [127:0] aes_ref(input logic [127:0] k, input logic [127:0] p);
        logic [31:0]  w [44];
        logic [7:0]   s [16];
        logic [7:0]   t [16];
        logic [31:0]  tmp;
        logic [7:0]   rc = 8'h01;
        logic [127:0] res;
        for (int i = 0; i < 4; i++) w[i] = k[127-32*i -: 32];
        for (int i = 4; i < 44; i++) begin
            tmp = w[i-1];
            if (i % 4 == 0) begin
                tmp = {tmp[23:0], tmp[31:24]};
                tmp = {sbox_tab[tmp[31:24]], sbox_tab[tmp[23:16]],
                       sbox_tab[tmp[15:8]],  sbox_tab[tmp[7:0]]};
                tmp[31:24] = tmp[31:24] ^ rc;
                rc = gmul(rc, 8'h02);
            end
            w[i] = w[i-4] ^ tmp;
        end
        for (int b = 0; b < 16; b++)
            s[b] = p[127-8*b -: 8] ^ w[b/4][31-8*(b%4) -: 8];
        for (int rd = 1; rd <= 10; rd++) begin
            for (int b = 0; b < 16; b++) s[b] = sbox_tab[s[b]];
            for (int c = 0; c < 4; c++)
                for (int r = 0; r < 4; r++)
                    t[4*c+r] = s[4*((c+r)%4)+r];
            for (int c = 0; c < 4; c++)
                for (int r = 0; r < 4; r++)
                    if (rd < 10)
                        s[4*c+r] = gmul(t[4*c+r], 8'h02) ^ gmul(t[4*c+(r+1)%4], 8'h03)
                                   ^ t[4*c+(r+2)%4] ^ t[4*c+(r+3)%4];
                    else
                        s[4*c+r] = t[4*c+r];
            for (int b = 0; b < 16; b++)
                s[b] = s[b] ^ w[4*rd + b/4][31-8*(b%4) -: 8];
        end
        for (int b = 0; b < 16; b++) res[127-8*b -: 8] = s[b];
        return res;
    endfunction

    function automatic logic [127:0] rand128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    // ------------------------------------------------------------------
    // Stimulus helpers
    // ------------------------------------------------------------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Launch one block and wait (bounded) for E_done. Optionally scramble
    // plaintext/key every cycle while the block runs.
    task automatic run_block(input logic [127:0] k, input logic [127:0] p,
                             input bit scramble, output int cycles,
                             output logic [127:0] ct);
        key       = k;
        plaintext = p;
        E_int     = 1'b1;
        tick();
        E_int  = 1'b0;
        cycles = 0;
        while (E_done !== 1'b1 && cycles < 20) begin
            if (scramble) begin
                key       = rand128();
                plaintext = rand128();
                E_int     = $urandom_range(0, 1);
            end
            tick();
            cycles++;
        end
        E_int = 1'b0;
        ct    = ciphertext;
    endtask

    // ------------------------------------------------------------------
    // Tests
    // ------------------------------------------------------------------
    task automatic test_reset();
        rst_n = 1'b1;
        E_int = 1'b0;
        plaintext = '0;
        key = '0;
        tick();
        tick();
        n_cmp++;
        if (ciphertext !== 128'h0 || E_done !== 1'b0) begin
            n_bad++;
            $display("FAIL reset_outputs: ct=%h done=%b, required ct=0 done=0", ciphertext, E_done);
        end
`ifdef ENC_BUSY_PORT_EN
        n_cmp++;
        if (busy !== 1'b0) begin
            n_bad++;
            $display("FAIL reset_busy: got %b required 0", busy);
        end
`endif
        rst_n = 1'b0;
        tick();
        $display("reset: ct=%h done=%b", ciphertext, E_done);
    endtask

    task automatic test_idle();
        int done_seen = 0;
        int ct_changed = 0;
        for (int i = 0; i < 30; i++) begin
            plaintext = rand128();
            key       = rand128();
            tick();
            if (E_done !== 1'b0) done_seen++;
            if (ciphertext !== 128'h0) ct_changed++;
        end
        n_cmp++;
        if (done_seen != 0) begin
            n_bad++;
            $display("FAIL idle_done: E_done high %0d cycles, required 0", done_seen);
        end
        n_cmp++;
        if (ct_changed != 0) begin
            n_bad++;
            $display("FAIL idle_ct: ct nonzero %0d cycles, required 0", ct_changed);
        end
        $display("idle: 30 cycles without start, done_seen=%0d ct_changed=%0d", done_seen, ct_changed);
    endtask

    task automatic test_fips197();
        logic [127:0] k  = 128'h000102030405060708090a0b0c0d0e0f;
        logic [127:0] p  = 128'h00112233445566778899aabbccddeeff;
        logic [127:0] ex = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
        logic [127:0] ct;
        int cycles;
        key = k;
        plaintext = p;
        E_int = 1'b1;
        tick();
        E_int = 1'b0;
`ifdef ENC_BUSY_PORT_EN
        n_cmp++;
        if (busy !== 1'b1) begin
            n_bad++;
            $display("FAIL busy_rise: got %b required 1 after start edge", busy);
        end
`endif
        cycles = 0;
        while (E_done !== 1'b1 && cycles < 20) begin
            tick();
            cycles++;
        end
        ct = ciphertext;
        n_cmp++;
        if (cycles != 10) begin
            n_bad++;
            $display("FAIL fips_latency: got %0d edges required 10", cycles);
        end
        n_cmp++;
        if (ct !== ex) begin
            n_bad++;
            $display("FAIL fips_ct: got %h required %h", ct, ex);
        end
        n_cmp++;
        if (ct !== aes_ref(k, p)) begin
            n_bad++;
            $display("FAIL fips_model: got %h model %h", ct, aes_ref(k, p));
        end
        tick();
        n_cmp++;
        if (E_done !== 1'b0 || ciphertext !== ex) begin
            n_bad++;
            $display("FAIL fips_pulse: done=%b ct=%h required done=0 ct=%h", E_done, ciphertext, ex);
        end
`ifdef ENC_BUSY_PORT_EN
        n_cmp++;
        if (busy !== 1'b0) begin
            n_bad++;
            $display("FAIL busy_fall: got %b required 0 after DONE", busy);
        end
`endif
        $display("fips197: key=%h pt=%h ct=%h latency=%0d", k, p, ct, cycles);
    endtask

    task automatic test_back_to_back();
        logic [127:0] k = 128'h2b7e151628aed2a6abf7158809cf4f3c;
        logic [127:0] pts [4];
        logic [127:0] exp_ct [4];
        int cycles;
        pts[0] = 128'h6bc1bee22e409f96e93d7e117393172a;
        pts[1] = 128'hae2d8a571e03ac9c9eb76fac45af8e51;
        pts[2] = 128'h30c81c46a35ce411e5fbc1191a0a52ef;
        pts[3] = 128'hf69f2445df4f9b17ad2b417be66c3710;
        exp_ct[0] = 128'h3ad77bb40d7a3660a89ecaf32466ef97;
        exp_ct[1] = 128'hf5d3d58503b9699de785895a96fdbaaf;
        exp_ct[2] = 128'h43b1cd7f598ece23881b00e3ed030688;
        exp_ct[3] = 128'h7b0c785e27e8ad3f8223207104725dd4;
        key = k;
        plaintext = pts[0];
        E_int = 1'b1;
        tick();
        plaintext = pts[1];
        for (int b = 0; b < 4; b++) begin
            cycles = 0;
            while (E_done !== 1'b1 && cycles < 30) begin
                tick();
                cycles++;
            end
            n_cmp++;
            if (ciphertext !== exp_ct[b] || cycles != 10) begin
                n_bad++;
                $display("FAIL b2b_block%0d: ct=%h after %0d edges, required %h after 10",
                         b, ciphertext, cycles, exp_ct[b]);
            end
            $display("b2b block %0d: pt=%h ct=%h edges=%0d", b, pts[b], ciphertext, cycles);
            if (b == 3) E_int = 1'b0;
            tick();
            tick();
            if (b < 2) plaintext = pts[b+2];
        end
        E_int = 1'b0;
        tick();
    endtask

    task automatic test_random();
        logic [127:0] k, p, ct, ex;
        int cycles;
        for (int i = 0; i < 6; i++) begin
            k = rand128();
            p = rand128();
            ex = aes_ref(k, p);
            run_block(k, p, 1'b1, cycles, ct);
            n_cmp++;
            if (ct !== ex || cycles != 10) begin
                n_bad++;
                $display("FAIL random%0d: ct=%h after %0d edges, required %h after 10",
                         i, ct, cycles, ex);
            end
            $display("random %0d: key=%h pt=%h ct=%h", i, k, p, ct);
            tick();
        end
    endtask

    task automatic test_reset_mid();
        logic [127:0] k = 128'h000102030405060708090a0b0c0d0e0f;
        logic [127:0] p = 128'h00112233445566778899aabbccddeeff;
        logic [127:0] ct;
        int cycles;
        int done_seen = 0;
        key = rand128();
        plaintext = rand128();
        E_int = 1'b1;
        tick();
        E_int = 1'b0;
        for (int i = 0; i < 4; i++) tick();
        #2 rst_n = 1'b1;
        #1;
        n_cmp++;
        if (ciphertext !== 128'h0 || E_done !== 1'b0) begin
            n_bad++;
            $display("FAIL midreset_async: ct=%h done=%b required 0/0", ciphertext, E_done);
        end
        tick();
        rst_n = 1'b0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (E_done !== 1'b0) done_seen++;
        end
        n_cmp++;
        if (done_seen != 0 || ciphertext !== 128'h0) begin
            n_bad++;
            $display("FAIL midreset_nodone: done_seen=%0d ct=%h required 0/0", done_seen, ciphertext);
        end
        run_block(k, p, 1'b0, cycles, ct);
        n_cmp++;
        if (ct !== 128'h69c4e0d86a7b0430d8cdb78070b4c55a || cycles != 10) begin
            n_bad++;
            $display("FAIL midreset_restart: ct=%h after %0d edges, required 69c4e0d86a7b0430d8cdb78070b4c55a after 10",
                     ct, cycles);
        end
        $display("reset_mid: abort ok, restart ct=%h", ct);
        tick();
    endtask

    initial begin
        build_sbox();
        test_reset();
        test_idle();
        test_fips197();
        test_back_to_back();
        test_random();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
